// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random pre-lamp delay, then counts ticks until the
// player presses. Reports the measured time, an early press, or a timeout.
module reaction_ctrl #(
   parameter int MIN_DELAY = 1000,
   parameter int MAX_REACT = 8191
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Tick,
   input  logic        Start,
   input  logic        Button,
   input  logic [12:0] RandomValue,
   output logic        LedOn,
   output logic        Busy,
   output logic        Done,
   output logic        EarlyFault,
   output logic        TimedOut,
   output logic [12:0] ReactionTime
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_REACT = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [13:0] min_delay_w = 14'(MIN_DELAY);
   localparam logic [12:0] max_react_w = 13'(MAX_REACT);

   state_t      state;
   state_t      next_state;
   logic [13:0] delay_cnt;
   logic [12:0] react_cnt;
   logic        button_q;
   logic        press;
   logic        delay_expired;
   logic        react_timeout;
   logic        led_d;
   logic        busy_d;

   // Only a rising edge counts as a press; a level held across rounds is ignored.
   assign press         = Button & ~button_q;
   assign delay_expired = (delay_cnt == 14'd0) || (Tick && (delay_cnt == 14'd1));
   assign react_timeout = Tick && (react_cnt == max_react_w);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, regardless of the order the statements are written in.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   // NOTE: each combinational output gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_FAULT: if (Start) next_state = ST_WAIT;
         ST_WAIT: begin
            if (press)              next_state = ST_FAULT;
            else if (delay_expired) next_state = ST_REACT;
         end
         ST_REACT: if (press || react_timeout) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Lamp and busy are decoded from the next state, so the registers track the state exactly.
   always_comb begin
      led_d  = (next_state == ST_REACT);
      busy_d = (next_state == ST_WAIT) || (next_state == ST_REACT);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         delay_cnt    <= '0;
         react_cnt    <= '0;
         button_q     <= 1'b0;
         LedOn        <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         EarlyFault   <= 1'b0;
         TimedOut     <= 1'b0;
         ReactionTime <= '0;
      end else begin
         button_q <= Button;
         LedOn    <= led_d;
         Busy     <= busy_d;
         Done     <= 1'b0;
         case (state)
            ST_IDLE, ST_FAULT: begin
               if (Start) begin
                  delay_cnt  <= min_delay_w + {1'b0, RandomValue};
                  EarlyFault <= 1'b0;
                  TimedOut   <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (press) begin
                  EarlyFault <= 1'b1;
               end else begin
                  if (Tick && (delay_cnt != 14'd0)) delay_cnt <= delay_cnt - 14'd1;
                  if (delay_expired)                 react_cnt <= '0;
               end
            end
            ST_REACT: begin
               // A press wins over a same-cycle tick, which is then not counted.
               if (press) begin
                  ReactionTime <= react_cnt;
                  Done         <= 1'b1;
               end else if (react_timeout) begin
                  ReactionTime <= max_react_w;
                  TimedOut     <= 1'b1;
               end else if (Tick) begin
                  react_cnt <= react_cnt + 13'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
